// File: rtl/replay_buffer_pkg.sv
// rtl/replay_buffer_pkg.sv - shared accelerator constants and bank-state types
// Purpose: default replay-buffer geometry, bank-state enum and cfg clamping helpers.
// Ports: none (package).
package replay_buffer_pkg;

  localparam int RB_WIDTH     = 64;
  localparam int RB_MAX_DEPTH = 128;
  // Group length is 1..256 after clamping, so it needs one bit more than cfg_len.
  localparam int RB_LEN_W     = 9;

  typedef enum logic {
    FREE = 1'b0,
    FULL = 1'b1
  } bank_state_e;

  // 0 means one word; anything beyond the bank depth is cut to the bank depth.
  function automatic logic [RB_LEN_W-1:0] clamp_len(input logic [7:0] cfg, input int max_depth);
    if (cfg == 8'd0) begin
      return RB_LEN_W'(1);
    end else if (int'(cfg) > max_depth) begin
      return RB_LEN_W'(max_depth);
    end else begin
      return {1'b0, cfg};
    end
  endfunction

  // 0 means a single pass.
  function automatic logic [7:0] clamp_reps(input logic [7:0] cfg);
    return (cfg == 8'd0) ? 8'd1 : cfg;
  endfunction

endpackage

// File: rtl/replay_bank_mem.sv
// rtl/replay_bank_mem.sv - one replay bank of distributed RAM
// Purpose: DEPTH x WIDTH storage, one synchronous write port, one asynchronous read port.
// Ports:
//   clk   - write clock (rising edge)
//   we    - write enable
//   waddr - write address
//   wdata - write data
//   raddr - read address
//   rdata - read data, combinational from raddr
module replay_bank_mem import replay_buffer_pkg::*; #(
  parameter int WIDTH = RB_WIDTH,
  parameter int DEPTH = RB_MAX_DEPTH,
  parameter int AW    = $clog2(RB_MAX_DEPTH)
) (
  input  logic             clk,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic [AW-1:0]    raddr,
  output logic [WIDTH-1:0] rdata
);

  logic [WIDTH-1:0] mem_q [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      mem_q[waddr] <= wdata;
    end
  end

  assign rdata = mem_q[raddr];

endmodule

// File: rtl/replay_buffer.sv
// rtl/replay_buffer.sv - two-bank ping-pong buffer that replays each group reps times
// Purpose: capture a group of len words into a free bank, then stream it out reps times
//          while the other bank fills.
// Ports:
//   clk, rst             - clock, synchronous active-high reset
//   cfg_len, cfg_reps    - group length / pass count, latched on a group's first word
//   in_valid/in_data/in_ready    - write-side handshake
//   out_valid/out_data/out_ready - read-side handshake
//   out_pass_end         - current word ends a pass
//   out_last             - current word ends the final pass of the group
module replay_buffer import replay_buffer_pkg::*; #(
  parameter int WIDTH     = RB_WIDTH,
  parameter int MAX_DEPTH = RB_MAX_DEPTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [7:0]       cfg_len,
  input  logic [7:0]       cfg_reps,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_data,
  output logic             in_ready,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_data,
  input  logic             out_ready,
  output logic             out_pass_end,
  output logic             out_last
);

  localparam int AW = $clog2(MAX_DEPTH);

  bank_state_e         bank_q [2];
  bank_state_e         bank_d [2];
  logic [RB_LEN_W-1:0] len_q  [2];
  logic [RB_LEN_W-1:0] len_d  [2];
  logic [7:0]          reps_q [2];
  logic [7:0]          reps_d [2];
  logic                wbank_q, wbank_d;
  logic                rbank_q, rbank_d;
  logic [AW-1:0]       wptr_q, wptr_d;
  logic [AW-1:0]       rptr_q, rptr_d;
  logic [7:0]          pass_q, pass_d;

  logic [RB_LEN_W-1:0] cfg_len_c;
  logic [7:0]          cfg_reps_c;
  logic [RB_LEN_W-1:0] wr_len;
  logic                wr_fire, wr_at_end;
  logic                rd_fire, rd_at_end;
  logic [WIDTH-1:0]    rdata0, rdata1;

  assign cfg_len_c  = clamp_len(cfg_len, MAX_DEPTH);
  assign cfg_reps_c = clamp_reps(cfg_reps);

  assign in_ready  = (bank_q[wbank_q] == FREE);
  assign wr_fire   = in_valid && in_ready;
  // The first word of a group ends it when len is 1, before the latched len exists,
  // so the live clamped cfg decides on that word.
  assign wr_len    = (wptr_q == '0) ? cfg_len_c : len_q[wbank_q];
  assign wr_at_end = (RB_LEN_W'(wptr_q) == wr_len - RB_LEN_W'(1));

  assign out_valid    = (bank_q[rbank_q] == FULL);
  assign rd_at_end    = (RB_LEN_W'(rptr_q) == len_q[rbank_q] - RB_LEN_W'(1));
  assign out_pass_end = out_valid && rd_at_end;
  assign out_last     = out_pass_end && (pass_q == reps_q[rbank_q] - 8'd1);
  assign rd_fire      = out_valid && out_ready;
  assign out_data     = rbank_q ? rdata1 : rdata0;

  always_comb begin
    bank_d  = bank_q;
    len_d   = len_q;
    reps_d  = reps_q;
    wbank_d = wbank_q;
    rbank_d = rbank_q;
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    pass_d  = pass_q;

    if (wr_fire) begin
      if (wptr_q == '0) begin
        len_d[wbank_q]  = cfg_len_c;
        reps_d[wbank_q] = cfg_reps_c;
      end
      if (wr_at_end) begin
        bank_d[wbank_q] = FULL;
        wbank_d         = ~wbank_q;
        wptr_d          = '0;
      end else begin
        wptr_d = wptr_q + AW'(1);
      end
    end

    // The write bank is FREE and the read bank FULL, so these never touch the same bank.
    if (rd_fire) begin
      if (rd_at_end) begin
        rptr_d = '0;
        if (out_last) begin
          pass_d          = '0;
          bank_d[rbank_q] = FREE;
          rbank_d         = ~rbank_q;
        end else begin
          pass_d = pass_q + 8'd1;
        end
      end else begin
        rptr_d = rptr_q + AW'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      bank_q[0] <= FREE;
      bank_q[1] <= FREE;
      len_q[0]  <= RB_LEN_W'(1);
      len_q[1]  <= RB_LEN_W'(1);
      reps_q[0] <= 8'd1;
      reps_q[1] <= 8'd1;
      wbank_q   <= 1'b0;
      rbank_q   <= 1'b0;
      wptr_q    <= '0;
      rptr_q    <= '0;
      pass_q    <= '0;
    end else begin
      bank_q  <= bank_d;
      len_q   <= len_d;
      reps_q  <= reps_d;
      wbank_q <= wbank_d;
      rbank_q <= rbank_d;
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      pass_q  <= pass_d;
    end
  end

  replay_bank_mem #(
    .WIDTH (WIDTH),
    .DEPTH (MAX_DEPTH),
    .AW    (AW)
  ) u_bank0 (
    .clk   (clk),
    .we    (wr_fire && !wbank_q),
    .waddr (wptr_q),
    .wdata (in_data),
    .raddr (rptr_q),
    .rdata (rdata0)
  );

  replay_bank_mem #(
    .WIDTH (WIDTH),
    .DEPTH (MAX_DEPTH),
    .AW    (AW)
  ) u_bank1 (
    .clk   (clk),
    .we    (wr_fire && wbank_q),
    .waddr (wptr_q),
    .wdata (in_data),
    .raddr (rptr_q),
    .rdata (rdata1)
  );

endmodule

// File: doc/replay_buffer.md
REPLAY_BUFFER -- requirements
Module: replay_buffer

Interface
REQ-001 SHALL have parameter WIDTH, default 64: data word width in bits.
REQ-002 SHALL have parameter MAX_DEPTH, default 128: words per bank; legal range 2..256.
REQ-003 SHALL have port clk  input  1: clock; all logic rising-edge.
REQ-004 SHALL have port rst  input  1: reset, synchronous, active-high.
REQ-005 SHALL have port cfg_len  input  8: words per group (Cin/8); 0 treated as 1; values above MAX_DEPTH clamp to MAX_DEPTH.
REQ-006 SHALL have port cfg_reps  input  8: replay passes per group; 0 treated as 1.
REQ-007 SHALL have port in_valid  input  1: write-side word valid.
REQ-008 SHALL have port in_data  input  WIDTH: write-side word.
REQ-009 SHALL have port in_ready  output  1: write side may accept a word.
REQ-010 SHALL have port out_valid  output  1: read-side word valid.
REQ-011 SHALL have port out_data  output  WIDTH: read-side word.
REQ-012 SHALL have port out_ready  input  1: downstream accepts the word.
REQ-013 SHALL have port out_pass_end  output  1: current word is the last word of a pass.
REQ-014 SHALL have port out_last  output  1: current word is the last word of the final pass of a group.

Function
REQ-015 SHALL hold two banks (0, 1) of MAX_DEPTH words, each with state FREE or FULL, plus a latched len and reps per bank.
REQ-016 SHALL transfer on the write side only when in_valid && in_ready, and on the read side only when out_valid && out_ready.
REQ-017 SHALL drive in_ready = 1 exactly when the write bank is FREE.
REQ-018 SHALL latch cfg_len/cfg_reps (after clamping) into the write bank on that bank's first accepted word; cfg changes mid-group SHALL NOT affect that group.
REQ-019 SHALL write accepted words at ascending addresses 0..len-1; on accepting word len-1, SHALL mark the bank FULL and toggle the write bank on the next edge.
REQ-020 SHALL drive out_valid = 1 exactly when the read bank is FULL; the first word is visible on the cycle after the bank's last write.
REQ-021 SHALL drive out_data = word[rptr] of the read bank, valid in the same cycle as out_valid (no extra read latency), stable while out_valid && !out_ready.
REQ-022 SHALL advance rptr on each read transfer; at rptr = len-1, SHALL wrap rptr to 0 and increment the pass counter.
REQ-023 SHALL assert out_pass_end when rptr = len-1, and out_last when rptr = len-1 and pass = reps-1.
REQ-024 SHALL, on the transfer with out_last, mark the read bank FREE, clear the pass counter, and toggle the read bank.
REQ-025 SHALL make a bank freed at edge C writable from cycle C+1; in the same cycle, a write into one bank and a read-free of the other SHALL both take effect.
REQ-026 SHALL sustain one write and one read per cycle when both banks are in use (ping-pong), with no bubbles at bank switches.
REQ-027 SHALL, with len = 1, emit the single word reps times, each with out_pass_end = 1.
REQ-028 SHALL hold in_ready = 0 while both banks are FULL; an in_valid held during that time SHALL NOT be lost or duplicated.

Reset
REQ-029 SHALL, on rst, set both banks FREE, write bank = read bank = 0, write pointer, rptr and pass counter = 0.
REQ-030 SHALL drive out_valid = 0, out_pass_end = 0, out_last = 0 and in_ready = 1 in the first cycle after reset.
REQ-031 SHALL discard all buffered data on reset mid-operation; memory contents need not be cleared.

Structure
REQ-032 SHALL take its default WIDTH and MAX_DEPTH constants, and the bank-state enum (FREE, FULL), from the shared accelerator package.
REQ-033 SHALL implement the storage as one sub-module replay_bank_mem: a distributed-RAM array with one synchronous write port and one asynchronous read port, instantiated twice.

Verification
REQ-034 SHALL verify: len=4, reps=3, words A0..A3, out_ready=1 -> output A0..A3 three times; out_pass_end on cycles 4, 8, 12; out_last only on the 12th word.
REQ-035 SHALL verify: two groups back-to-back (len=8, reps=2), in_valid=1 -> in_ready stays 1 while the second bank fills; output is continuous, 32 words with no gaps.
REQ-036 SHALL verify: len=1, reps=5, word X -> X emitted 5 times, out_pass_end=1 on all 5, out_last on the 5th.
REQ-037 SHALL verify: out_ready toggled pseudo-randomly -> out_data stable while stalled; sequence identical to the unstalled case.
REQ-038 SHALL verify: both banks FULL, in_valid=1 -> in_ready=0; the held word is accepted exactly once on the cycle after the first bank frees.
REQ-039 SHALL verify: rst asserted mid-replay -> out_valid=0 and in_ready=1 the next cycle; a new group len=2 then replays correctly.
